// File: rtl/aes256_byte_collector_pkg.sv
// ---------------------------------------------------------------------------
// aes256_byte_collector_pkg
// Shared types and widths for the AES-256 ciphertext byte collector.
//   collector_state_t : FSM encoding (IDLE, REQ, WAIT, OUT)
//   AES_BLK_W         : width of one AES block in bits
//   AES_BYTE_W        : width of one transferred byte
// ---------------------------------------------------------------------------
package aes256_byte_collector_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    WAIT = 2'd2,
    OUT  = 2'd3
  } collector_state_t;

  localparam int AES_BLK_W  = 128;
  localparam int AES_BYTE_W = 8;

endpackage

// File: rtl/aes256_byte_collector.sv
// ---------------------------------------------------------------------------
// aes256_byte_collector
// Pulls the 16 ciphertext bytes of one AES block from the loading core, one
// request per byte, packs them into a 128-bit block (first byte in the top
// byte) and offers the block downstream.
//
// Handshakes:
//   byte side  : po_next_val_req pulses for one cycle; the core answers with
//                pi_next_val_ready (+pi_data) one or more cycles later. A
//                strobe is only accepted while the FSM is in WAIT.
//   block side : po_block_valid stays high and po_block stays stable until
//                pi_block_ready is seen high; the transfer happens on the
//                cycle where valid & ready are both 1.
//
// Ports:
//   clk               clock, rising edge
//   rst               asynchronous, active-low reset
//   pi_enc_done       pulse: new ciphertext block available in the core
//   po_next_val_req   pulse: request next byte
//   pi_next_val_ready byte strobe, pi_data valid
//   pi_data           ciphertext byte
//   po_block_valid    assembled block available
//   pi_block_ready    consumer accepts the block
//   po_block          assembled block, first byte in [127:120]
//   po_byte_cnt       bytes received in current block (saturates at 15)
//   po_busy           FSM not idle
//   po_timeout        pulse: byte wait expired, block dropped
//   po_overrun        pulse: pi_enc_done arrived while busy (ignored)
//   po_state          current FSM state, for observation
// ---------------------------------------------------------------------------
module aes256_byte_collector
  import aes256_byte_collector_pkg::*;
#(
  parameter int BYTES_PER_BLK = 16,
  parameter int TIMEOUT_CYC   = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pi_enc_done,
  output logic                  po_next_val_req,
  input  logic                  pi_next_val_ready,
  input  logic [AES_BYTE_W-1:0] pi_data,
  output logic                  po_block_valid,
  input  logic                  pi_block_ready,
  output logic [AES_BLK_W-1:0]  po_block,
  output logic [3:0]            po_byte_cnt,
  output logic                  po_busy,
  output logic                  po_timeout,
  output logic                  po_overrun,
  output collector_state_t      po_state
);

  localparam int              TO_W     = $clog2(TIMEOUT_CYC);
  localparam logic [TO_W-1:0] TO_LAST  = TO_W'(TIMEOUT_CYC - 1);
  localparam logic [3:0]      CNT_LAST = 4'(BYTES_PER_BLK - 1);

  collector_state_t       r_state;
  logic [3:0]             r_byte_cnt;
  logic [TO_W-1:0]        r_to_cnt;
  logic [AES_BLK_W-1:0]   r_sr;
  logic                   r_timeout;
  logic                   r_overrun;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= IDLE;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
      r_sr       <= '0;
      r_timeout  <= 1'b0;
      r_overrun  <= 1'b0;
    end else begin
      r_timeout <= 1'b0;
      // A new block while busy is dropped here; the core keeps it.
      r_overrun <= pi_enc_done && (r_state != IDLE);

      case (r_state)
        IDLE: begin
          if (pi_enc_done) begin
            r_state    <= REQ;
            r_byte_cnt <= '0;
          end
        end

        REQ: begin
          r_state  <= WAIT;
          r_to_cnt <= '0;
        end

        WAIT: begin
          if (pi_next_val_ready) begin
            r_sr <= {r_sr[AES_BLK_W-AES_BYTE_W-1:0], pi_data};
            if (r_byte_cnt == CNT_LAST) begin
              // Count holds at 15 in OUT; it only returns to 0 on the transfer.
              r_state <= OUT;
            end else begin
              r_byte_cnt <= r_byte_cnt + 4'd1;
              r_state    <= REQ;
            end
          end else if (r_to_cnt == TO_LAST) begin
            r_timeout  <= 1'b1;
            r_byte_cnt <= '0;
            r_state    <= IDLE;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end

        OUT: begin
          if (pi_block_ready) begin
            r_state    <= IDLE;
            r_byte_cnt <= '0;
          end
        end

        default: r_state <= IDLE;
      endcase
    end
  end

  // All outputs are decodes of registers only.
  assign po_next_val_req = (r_state == REQ);
  assign po_block_valid  = (r_state == OUT);
  assign po_busy         = (r_state != IDLE);
  assign po_block        = r_sr;
  assign po_byte_cnt     = r_byte_cnt;
  assign po_timeout      = r_timeout;
  assign po_overrun      = r_overrun;
  assign po_state        = r_state;

endmodule

// File: tb/tb_aes256_byte_collector.sv
module tb_aes256_byte_collector;
  import aes256_byte_collector_pkg::*;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic             pi_enc_done = 1'b0;
  logic             po_next_val_req;
  logic             pi_next_val_ready = 1'b0;
  logic [7:0]       pi_data = 8'h00;
  logic             po_block_valid;
  logic             pi_block_ready = 1'b0;
  logic [127:0]     po_block;
  logic [3:0]       po_byte_cnt;
  logic             po_busy;
  logic             po_timeout;
  logic             po_overrun;
  collector_state_t po_state;

  aes256_byte_collector #(.BYTES_PER_BLK(16), .TIMEOUT_CYC(64)) dut (
    .clk               (clk),
    .rst               (rst),
    .pi_enc_done       (pi_enc_done),
    .po_next_val_req   (po_next_val_req),
    .pi_next_val_ready (pi_next_val_ready),
    .pi_data           (pi_data),
    .po_block_valid    (po_block_valid),
    .pi_block_ready    (pi_block_ready),
    .po_block          (po_block),
    .po_byte_cnt       (po_byte_cnt),
    .po_busy           (po_busy),
    .po_timeout        (po_timeout),
    .po_overrun        (po_overrun),
    .po_state          (po_state)
  );

  int checks = 0;
  int errors = 0;

  // Pulse monitors, sampled mid-cycle.
  int req_cnt = 0;
  int ovr_cnt = 0;
  int tmo_cnt = 0;
  int val_cnt = 0;
  always @(negedge clk) begin
    if (po_next_val_req) req_cnt++;
    if (po_overrun)      ovr_cnt++;
    if (po_timeout)      tmo_cnt++;
    if (po_block_valid)  val_cnt++;
  end

  localparam logic [127:0] C3_CT  = 128'h8ea2b7ca516745bfeafc49904b496089;
  localparam logic [127:0] SEQ_CT = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [127:0] B10_CT = 128'h101112131415161718191a1b1c1d1e1f;

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic start_block();
    pi_enc_done = 1'b1;
    tick();
    pi_enc_done = 1'b0;
  endtask

  // Wait for the request, check the running count, strobe after d cycles.
  task automatic feed_byte(input logic [7:0] b, input int d, input int idx);
    int n;
    n = 0;
    while (!po_next_val_req && n < 200) begin
      tick();
      n++;
    end
    checks++;
    if (!po_next_val_req) begin
      errors++;
      $display("FAIL req_wait byte %0d: no request within 200 cycles", idx);
    end
    checks++;
    if (po_byte_cnt !== 4'(idx)) begin
      errors++;
      $display("FAIL byte_cnt byte %0d: got %0d expected %0d", idx, po_byte_cnt, idx);
    end
    for (int i = 0; i < d; i++) tick();
    pi_next_val_ready = 1'b1;
    pi_data           = b;
    tick();
    pi_next_val_ready = 1'b0;
  endtask

  task automatic feed_range(input logic [127:0] blk, input int first, input int last,
                            input bit rand_dly);
    logic [127:0] v;
    v = blk;
    for (int i = first; i <= last; i++)
      feed_byte(v[127-8*i -: 8], rand_dly ? int'($urandom_range(1, 20)) : 1, i);
  endtask

  task automatic accept_block(input logic [127:0] exp, input string name);
    checks++;
    if (po_block_valid !== 1'b1 || po_block !== exp) begin
      errors++;
      $display("FAIL %s_block: valid=%0b block=%h expected valid=1 block=%h",
               name, po_block_valid, po_block, exp);
    end
    pi_block_ready = 1'b1;
    tick();
    pi_block_ready = 1'b0;
    checks++;
    if (po_block_valid !== 1'b0 || po_busy !== 1'b0 || po_byte_cnt !== 4'd0 ||
        po_block !== exp) begin
      errors++;
      $display("FAIL %s_after_xfer: valid=%0b busy=%0b cnt=%0d block=%h expected 0 0 0 %h",
               name, po_block_valid, po_busy, po_byte_cnt, po_block, exp);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    #2;
    checks++;
    if (po_next_val_req !== 0 || po_block_valid !== 0 || po_block !== '0 ||
        po_byte_cnt !== 0 || po_busy !== 0 || po_timeout !== 0 || po_overrun !== 0 ||
        po_state !== IDLE) begin
      errors++;
      $display("FAIL reset_state: req=%0b valid=%0b block=%h cnt=%0d busy=%0b state=%0d expected all 0",
               po_next_val_req, po_block_valid, po_block, po_byte_cnt, po_busy, po_state);
    end
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_fips_block();
    start_block();
    feed_range(C3_CT, 0, 15, 1'b0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (po_block_valid !== 1'b1 || po_block !== C3_CT || po_byte_cnt !== 4'd15) begin
        errors++;
        $display("FAIL fips_hold cycle %0d: valid=%0b block=%h cnt=%0d expected 1 %h 15",
                 i, po_block_valid, po_block, po_byte_cnt, C3_CT);
      end
      tick();
    end
    accept_block(C3_CT, "fips");
  endtask

  task automatic test_random_delay();
    int req0;
    req0 = req_cnt;
    start_block();
    feed_range(C3_CT, 0, 15, 1'b1);
    checks++;
    if (req_cnt - req0 !== 16) begin
      errors++;
      $display("FAIL rand_req_count: got %0d expected 16", req_cnt - req0);
    end
    accept_block(C3_CT, "rand");
  endtask

  task automatic test_timeout();
    int tmo0, val0, n;
    tmo0 = tmo_cnt;
    val0 = val_cnt;
    start_block();
    feed_range(C3_CT, 0, 4, 1'b0);
    n = 0;
    while (!po_next_val_req && n < 20) begin tick(); n++; end
    // REQ cycle, then 64 WAIT cycles, the pulse shows after the 65th edge.
    n = 0;
    while (!po_timeout && n < 200) begin tick(); n++; end
    checks++;
    if (po_timeout !== 1'b1 || n !== 65) begin
      errors++;
      $display("FAIL timeout_pulse: seen=%0b after %0d cycles expected 1 after 65", po_timeout, n);
    end
    checks++;
    if (po_state !== IDLE || po_byte_cnt !== 4'd0 || po_busy !== 1'b0 || val_cnt !== val0) begin
      errors++;
      $display("FAIL timeout_state: state=%0d cnt=%0d busy=%0b valids=%0d expected 0 0 0 0",
               po_state, po_byte_cnt, po_busy, val_cnt - val0);
    end
    tick();
    checks++;
    if (po_timeout !== 1'b0 || tmo_cnt - tmo0 !== 1) begin
      errors++;
      $display("FAIL timeout_once: pulse=%0b count=%0d expected 0 1", po_timeout, tmo_cnt - tmo0);
    end
  endtask

  task automatic test_overrun();
    int ovr0, n;
    logic [127:0] v;
    ovr0 = ovr_cnt;
    v = C3_CT;
    start_block();
    feed_range(C3_CT, 0, 6, 1'b0);
    n = 0;
    while (!po_next_val_req && n < 20) begin tick(); n++; end
    tick();                       // now in WAIT for byte 7
    pi_enc_done = 1'b1;
    tick();
    pi_enc_done = 1'b0;
    checks++;
    if (po_overrun !== 1'b1 || po_state !== WAIT || po_byte_cnt !== 4'd7) begin
      errors++;
      $display("FAIL overrun_wait: ovr=%0b state=%0d cnt=%0d expected 1 2 7",
               po_overrun, po_state, po_byte_cnt);
    end
    pi_next_val_ready = 1'b1;
    pi_data           = v[127-8*7 -: 8];
    tick();
    pi_next_val_ready = 1'b0;
    feed_range(C3_CT, 8, 15, 1'b0);
    pi_enc_done = 1'b1;           // while OUT, ready low
    tick();
    pi_enc_done = 1'b0;
    checks++;
    if (po_overrun !== 1'b1 || po_block_valid !== 1'b1) begin
      errors++;
      $display("FAIL overrun_out: ovr=%0b valid=%0b expected 1 1", po_overrun, po_block_valid);
    end
    accept_block(C3_CT, "ovr");
    checks++;
    if (ovr_cnt - ovr0 !== 2) begin
      errors++;
      $display("FAIL overrun_count: got %0d expected 2", ovr_cnt - ovr0);
    end
  endtask

  task automatic test_async_reset();
    int req0;
    start_block();
    feed_range(C3_CT, 0, 9, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (po_next_val_req !== 0 || po_block_valid !== 0 || po_block !== '0 ||
        po_byte_cnt !== 0 || po_busy !== 0 || po_timeout !== 0 || po_overrun !== 0) begin
      errors++;
      $display("FAIL async_reset: req=%0b valid=%0b block=%h cnt=%0d busy=%0b expected all 0",
               po_next_val_req, po_block_valid, po_block, po_byte_cnt, po_busy);
    end
    tick();
    rst = 1'b1;
    req0 = req_cnt;
    for (int i = 0; i < 4; i++) tick();
    checks++;
    if (po_busy !== 1'b0 || req_cnt !== req0) begin
      errors++;
      $display("FAIL reset_quiet: busy=%0b reqs=%0d expected 0 0", po_busy, req_cnt - req0);
    end
    start_block();
    feed_range(SEQ_CT, 0, 15, 1'b0);
    accept_block(SEQ_CT, "post_rst");
  endtask

  task automatic test_unsolicited();
    pi_next_val_ready = 1'b1;
    pi_data           = 8'hAA;
    tick();
    tick();
    pi_next_val_ready = 1'b0;
    checks++;
    if (po_busy !== 1'b0 || po_byte_cnt !== 4'd0 || po_block !== SEQ_CT) begin
      errors++;
      $display("FAIL idle_strobe: busy=%0b cnt=%0d block=%h expected 0 0 %h",
               po_busy, po_byte_cnt, po_block, SEQ_CT);
    end
    start_block();                // now in REQ
    pi_next_val_ready = 1'b1;
    pi_data           = 8'h55;
    tick();
    pi_next_val_ready = 1'b0;
    checks++;
    if (po_state !== WAIT || po_byte_cnt !== 4'd0 || po_block !== SEQ_CT) begin
      errors++;
      $display("FAIL req_strobe: state=%0d cnt=%0d block=%h expected 2 0 %h",
               po_state, po_byte_cnt, po_block, SEQ_CT);
    end
    pi_next_val_ready = 1'b1;
    pi_data           = 8'h10;
    tick();
    pi_next_val_ready = 1'b0;
    feed_range(B10_CT, 1, 15, 1'b0);
    accept_block(B10_CT, "unsol");
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_fips_block();
    test_random_delay();
    test_timeout();
    test_overrun();
    test_async_reset();
    test_unsolicited();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
